// File: rtl/drm_20x256_rd_streamer.sv
// Read-side burst engine for the 20x256 simple-dual-port DRM: issues sequential
// reads and turns the fixed-latency RAM output into a valid/ready stream.
module drm_20x256_rd_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 20,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt, last_addr;
  logic [ADDR_WIDTH:0]   issue_cnt, beat_cnt;
  logic [RD_LATENCY:1]   vld_pipe;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count, inflight;
  logic                  hs, issue, credit, push, pop, last_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Credit covers reads still in the RAM pipe, so a capture always has a free slot.
  assign credit      = (inflight + fifo_count) < CW'(FIFO_DEPTH);
  assign issue       = (state == RUN) && credit;
  assign push        = vld_pipe[RD_LATENCY];
  assign hs          = cmd_valid && cmd_ready;
  assign pop         = m_valid && m_ready;
  assign last_pop    = pop && (beat_cnt == (ADDR_WIDTH + 1)'(1));

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? addr_cnt : last_addr;
  assign m_valid     = (fifo_count != '0);
  assign m_data      = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last      = m_valid && (beat_cnt == (ADDR_WIDTH + 1)'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = (cmd_len == '0) ? FIN : RUN;
      RUN:   if (issue && issue_cnt == (ADDR_WIDTH + 1)'(1)) state_nxt = DRAIN;
      DRAIN: if (last_pop && inflight == '0 && fifo_count == CW'(1)) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      last_addr  <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      vld_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_nxt;
      if (hs && cmd_len != '0) begin
        addr_cnt  <= cmd_addr;
        issue_cnt <= cmd_len;
        beat_cnt  <= cmd_len;
      end else begin
        if (issue) begin
          addr_cnt  <= addr_cnt + 1'b1;
          issue_cnt <= issue_cnt - 1'b1;
          last_addr <= addr_cnt;
        end
        if (pop) beat_cnt <= beat_cnt - 1'b1;
      end
      vld_pipe[1] <= issue;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: m_data is gated by m_valid.
  always_ff @(posedge rd_clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rd_data;
  end

  a_no_push_when_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(push && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_drm_20x256_rd_streamer.sv
// Bench for drm_20x256_rd_streamer: RD_LATENCY=1 and RD_LATENCY=2 instances run
// the same command/ready stimulus against a RAM model and a per-burst beat model.
module tb_drm_20x256_rd_streamer;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       cmd_valid = 0;
  logic [7:0] cmd_addr = 0;
  logic [8:0] cmd_len = 0;
  logic       m_ready = 0;

  logic        cmd_ready [2];
  logic        ram_rd_en [2];
  logic        m_valid   [2];
  logic        m_last    [2];
  logic        busy      [2];
  logic        done      [2];
  logic [7:0]  ram_rd_addr [2];
  logic [19:0] ram_rd_data [2];
  logic [19:0] m_data      [2];

  logic [19:0] mem [256];
  logic [19:0] ram_p1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM read port models: 1-cycle and 2-cycle latency
  always @(posedge clk) begin
    ram_rd_data[0] <= mem[ram_rd_addr[0]];
    ram_p1         <= mem[ram_rd_addr[1]];
    ram_rd_data[1] <= ram_p1;
  end

  drm_20x256_rd_streamer #(.RD_LATENCY(1)) dut0 (
    .rd_clk(clk), .rd_rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr[0]),
    .ram_rd_en(ram_rd_en[0]), .ram_rd_data(ram_rd_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .m_data(m_data[0]), .m_last(m_last[0]), .busy(busy[0]),
    .done(done[0]));

  drm_20x256_rd_streamer #(.RD_LATENCY(2)) dut1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr[1]),
    .ram_rd_en(ram_rd_en[1]), .ram_rd_data(ram_rd_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .m_data(m_data[1]), .m_last(m_last[1]), .busy(busy[1]),
    .done(done[1]));

  // Observation records, written only by the monitor below
  int          n_beat [2], n_iss [2], n_done [2], outst [2], max_out [2];
  int          hs_cyc [2], fv_cyc [2], fp_cyc [2], lp_cyc [2], done_cyc [2];
  int          stab_err [2], cred_err [2], rdy_err [2];
  logic [19:0] obs_data [2][512];
  logic        obs_last [2][512];
  logic [7:0]  obs_addr [2][512];
  logic        prev_stall [2], prev_last [2];
  logic [19:0] prev_data [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_beat[i] = 0; n_iss[i] = 0; n_done[i] = 0; outst[i] = 0; max_out[i] = 0;
      hs_cyc[i] = 0; fv_cyc[i] = -1; fp_cyc[i] = 0; lp_cyc[i] = 0; done_cyc[i] = 0;
      stab_err[i] = 0; cred_err[i] = 0; rdy_err[i] = 0;
      prev_stall[i] = 0; prev_last[i] = 0; prev_data[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        outst[i] = 0;
        prev_stall[i] = 0;
      end else begin
        if (cmd_valid && cmd_ready[i]) begin
          hs_cyc[i] = cyc; n_beat[i] = 0; n_iss[i] = 0; fv_cyc[i] = -1; max_out[i] = 0;
        end
        if (m_valid[i] && fv_cyc[i] < 0) fv_cyc[i] = cyc;
        if (prev_stall[i] && (!m_valid[i] || m_data[i] !== prev_data[i] ||
                              m_last[i] !== prev_last[i])) stab_err[i]++;
        if (ram_rd_en[i]) begin
          if (n_iss[i] < 512) obs_addr[i][n_iss[i]] = ram_rd_addr[i];
          n_iss[i]++;
          outst[i]++;
        end
        if (outst[i] > max_out[i]) max_out[i] = outst[i];
        if (outst[i] > i + 3) cred_err[i]++;
        if (m_valid[i] && m_ready) begin
          if (n_beat[i] == 0) fp_cyc[i] = cyc;
          if (n_beat[i] < 512) begin
            obs_data[i][n_beat[i]] = m_data[i];
            obs_last[i][n_beat[i]] = m_last[i];
          end
          if (m_last[i]) lp_cyc[i] = cyc;
          n_beat[i]++;
          outst[i]--;
        end
        if (done[i]) begin
          n_done[i]++;
          done_cyc[i] = cyc;
          if (cmd_ready[i]) rdy_err[i]++;
        end
        prev_stall[i] = m_valid[i] && !m_ready;
        prev_data[i]  = m_data[i];
        prev_last[i]  = m_last[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string ph);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_d%0d_cmd_ready", ph, i), 64'(cmd_ready[i]), 1);
      chk($sformatf("%s_d%0d_rd_addr", ph, i), 64'(ram_rd_addr[i]), 0);
      chk($sformatf("%s_d%0d_rd_en", ph, i), 64'(ram_rd_en[i]), 0);
      chk($sformatf("%s_d%0d_m_valid", ph, i), 64'(m_valid[i]), 0);
      chk($sformatf("%s_d%0d_m_last", ph, i), 64'(m_last[i]), 0);
      chk($sformatf("%s_d%0d_m_data", ph, i), 64'(m_data[i]), 0);
      chk($sformatf("%s_d%0d_busy", ph, i), 64'(busy[i]), 0);
      chk($sformatf("%s_d%0d_done", ph, i), 64'(done[i]), 0);
    end
  endtask

  // mode 0: always ready; 1: hold off 8 cycles then 1,0,0,...; 2: random
  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c >= 8) && ((c - 8) % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_burst(input int a, input int len, input int mode);
    int d [2];
    bit ok;
    d[0] = n_done[0]; d[1] = n_done[1]; ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_addr = 8'(a); cmd_len = 9'(len); m_ready = rdy(mode, 0);
    for (int c = 1; c < 3000 && !ok; c++) begin
      @(posedge clk); #1;
      cmd_valid = 0;
      m_ready = rdy(mode, c);
      if (mode == 1 && c == 8) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("d%0d_issues_at_credit_limit", i), 64'(n_iss[i]), 64'(i + 3));
          chk($sformatf("d%0d_max_outstanding", i), 64'(max_out[i]), 64'(i + 3));
        end
      end
      ok = (n_done[0] != d[0]) && (n_done[1] != d[1]);
    end
    m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      string p;
      p = $sformatf("a%0h_l%0d_d%0d", a, len, i);
      chk({p, "_done_count"}, 64'(n_done[i] - d[i]), 1);
      chk({p, "_beats"}, 64'(n_beat[i]), 64'(len));
      chk({p, "_issues"}, 64'(n_iss[i]), 64'(len));
      for (int k = 0; k < len; k++) begin
        chk($sformatf("%s_addr%0d", p, k), 64'(obs_addr[i][k]), 64'((a + k) % 256));
        chk($sformatf("%s_data%0d", p, k), 64'(obs_data[i][k]), 64'(mem[(a + k) % 256]));
        chk($sformatf("%s_last%0d", p, k), 64'(obs_last[i][k]), 64'(k == len - 1));
      end
      if (len > 0) begin
        chk({p, "_first_valid_lat"}, 64'(fv_cyc[i] - hs_cyc[i]), 64'(2 + i + 1));
        chk({p, "_done_after_last"}, 64'(done_cyc[i] - lp_cyc[i]), 1);
        if (mode == 0) chk({p, "_no_bubbles"}, 64'(lp_cyc[i] - fp_cyc[i]), 64'(len - 1));
      end else begin
        chk({p, "_no_valid"}, 64'(fv_cyc[i]), 64'(-1));
        chk({p, "_done_at_t1"}, 64'(done_cyc[i] - hs_cyc[i]), 1);
      end
      chk({p, "_idle_ready"}, 64'(cmd_ready[i]), 1);
      chk({p, "_idle_busy"}, 64'(busy[i]), 0);
      chk({p, "_stall_stable_errs"}, 64'(stab_err[i]), 0);
      chk({p, "_credit_errs"}, 64'(cred_err[i]), 0);
      chk({p, "_ready_in_done_errs"}, 64'(rdy_err[i]), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int a, d0, d1;
    bit hit;
    for (int k = 0; k < 256; k++) mem[k] = 20'(k * 3);

    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    rst_n = 1;

    run_burst(8'h10, 4, 0);
    run_burst(8'hFE, 4, 0);
    run_burst($urandom_range(0, 255), 6, 1);
    run_burst(8'h33, 0, 0);
    run_burst(8'h80, 256, 0);

    for (int k = 0; k < 256; k++) mem[k] = 20'($urandom);
    for (int n = 0; n < 4; n++) run_burst($urandom_range(0, 255), $urandom_range(1, 40), 2);

    // Reset in the middle of a 10-beat burst
    d0 = n_done[0]; d1 = n_done[1]; hit = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_addr = 8'($urandom); cmd_len = 9'd10; m_ready = 1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #1;
      cmd_valid = 0;
      hit = (n_beat[0] >= 3);
    end
    chk("midreset_reached_beat3", 64'(hit), 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk_rst("midreset");
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_done_d0", 64'(n_done[0] - d0), 0);
    chk("midreset_no_done_d1", 64'(n_done[1] - d1), 0);
    run_burst($urandom_range(0, 255), 12, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
